prog_counter: RTL and testbench

- Parametrised synchronous up/down counter with parallel load, programmable modulus, prescaler and one-shot mode.
- Emits a terminal-count pulse and a sticky overflow flag.
- Provides the general-purpose event and timer counter for the datapath.
- Supersedes the fixed 8-bit free-running load counter.

---
 rtl/prog_counter_if.sv | 35 +++
 rtl/prog_counter.sv | 98 +++++++++
 tb/tb_prog_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter_if
//  Purpose  : Control/status bundle for prog_counter. The master drives the
//             control inputs and the slave (the counter) returns the status.
//  Revision : 1.0  initial release
// ============================================================================
interface prog_counter_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] max_val;
    logic             oneshot;
    logic [PSC_W-1:0] prescale;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             done;

    modport master (
        output en, load, load_val, dir, max_val, oneshot, prescale, clr_ovf,
        input  count, tc, ovf, done
    );

    modport slave (
        input  en, load, load_val, dir, max_val, oneshot, prescale, clr_ovf,
        output count, tc, ovf, done
    );
endinterface
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter
//  Purpose  : Up/down counter with parallel load, programmable modulus,
//             prescaler, one-shot mode, terminal-count pulse and sticky
//             overflow flag. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module prog_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    prog_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] c_CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] c_PSC_ZERO = '0;
    localparam logic [PSC_W-1:0] c_PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PSC_W-1:0] r_psc;
    logic             r_tc;
    logic             r_ovf;
    logic             r_done;

    // Step qualification and terminal detection from the current count.
    // Up-count uses >= so an out-of-range load or a lowered modulus still ends.
    logic w_step;
    logic w_term;
    assign w_step = (r_state == RUN) && bus.en && (r_psc == bus.prescale);
    assign w_term = bus.dir ? (r_count >= bus.max_val) : (r_count == c_CNT_ZERO);

    // Counter state machine: load, prescaler, stepping and one-shot stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_count <= c_CNT_ZERO;
            r_psc   <= c_PSC_ZERO;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_count <= bus.load_val;
                r_psc   <= c_PSC_ZERO;
                r_state <= RUN;
                r_done  <= 1'b0;
            end else if (r_state == RUN && bus.en) begin
                if (w_step) begin
                    r_psc <= c_PSC_ZERO;
                    if (w_term) begin
                        r_tc <= 1'b1;
                        if (bus.oneshot) begin
                            // Hold the current count; down-count holds at 0.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= bus.dir ? c_CNT_ZERO : bus.max_val;
                        end
                    end else begin
                        r_count <= bus.dir ? (r_count + c_CNT_ONE)
                                           : (r_count - c_CNT_ONE);
                    end
                end else begin
                    // Wraps naturally if prescale was lowered below psc.
                    r_psc <= r_psc + c_PSC_ONE;
                end
            end
        end
    end

    // Sticky overflow: set by a visible tc pulse, which beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_tc) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_counter
//  Purpose  : Self-checking bench for prog_counter using a table of directed
//             vectors plus hand-written one-shot and back-to-back sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_counter;

    localparam int WIDTH = 8;
    localparam int PSC_W = 4;

    logic clk;
    logic rst;

    prog_counter_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

    prog_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             en;
        logic             load;
        logic [WIDTH-1:0] lv;
        logic             dir;
        logic [WIDTH-1:0] mx;
        logic             os;
        logic [PSC_W-1:0] ps;
        logic             clr;
        logic [WIDTH-1:0] e_count;
        logic             e_tc;
        logic             e_ovf;
        logic             e_done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_pass;

    function automatic vec_t mk(
        input logic rst_i, input logic en_i, input logic load_i, input int lv_i,
        input logic dir_i, input int mx_i, input logic os_i, input int ps_i,
        input logic clr_i,
        input int cnt_e, input logic tc_e, input logic ovf_e, input logic done_e
    );
        vec_t v;
        v.rst     = rst_i;
        v.en      = en_i;
        v.load    = load_i;
        v.lv      = lv_i[WIDTH-1:0];
        v.dir     = dir_i;
        v.mx      = mx_i[WIDTH-1:0];
        v.os      = os_i;
        v.ps      = ps_i[PSC_W-1:0];
        v.clr     = clr_i;
        v.e_count = cnt_e[WIDTH-1:0];
        v.e_tc    = tc_e;
        v.e_ovf   = ovf_e;
        v.e_done  = done_e;
        return v;
    endfunction

    // Drive one vector, clock it in, then compare the registered outputs.
    task automatic apply(input vec_t v, input string name);
        rst          = v.rst;
        bus.en       = v.en;
        bus.load     = v.load;
        bus.load_val = v.lv;
        bus.dir      = v.dir;
        bus.max_val  = v.mx;
        bus.oneshot  = v.os;
        bus.prescale = v.ps;
        bus.clr_ovf  = v.clr;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.count === v.e_count && bus.tc === v.e_tc &&
            bus.ovf === v.e_ovf && bus.done === v.e_done) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d tc=%b ovf=%b done=%b, expected count=%0d tc=%b ovf=%b done=%b",
                     name, bus.count, bus.tc, bus.ovf, bus.done,
                     v.e_count, v.e_tc, v.e_ovf, v.e_done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.dir = 1'b1;
        bus.max_val = '0; bus.oneshot = 1'b0; bus.prescale = '0; bus.clr_ovf = 1'b0;

        //                rst en ld lv  dir mx  os ps clr | cnt tc ovf done
        // Reset, then up-count modulo 6 with wrap.
        vecs.push_back(mk(1, 0, 0, 0,   1, 5,   0, 0, 0,   0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   2,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   3,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   4,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   5,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 5,   0, 0, 0,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 5,   0, 0, 1,   1,  0, 0, 0));
        // Down-count with prescale=2: a step every third enabled cycle.
        vecs.push_back(mk(0, 1, 1, 2,   0, 9,   0, 2, 0,   2,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   2,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   2,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   1,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   9,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 9,   0, 2, 0,   9,  0, 1, 0));
        // Clear in the tc cycle loses to set; clear one cycle later works.
        vecs.push_back(mk(0, 1, 1, 7,   1, 7,   0, 0, 0,   7,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 7,   0, 0, 0,   0,  1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 7,   0, 0, 1,   0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 7,   0, 0, 1,   0,  0, 0, 0));
        // Load at a terminal step wins, no tc.
        vecs.push_back(mk(0, 1, 1, 7,   1, 7,   0, 0, 0,   7,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3,   1, 7,   0, 0, 0,   3,  0, 0, 0));
        // Out-of-range load terminates; then lowered max_val terminates.
        vecs.push_back(mk(0, 0, 1, 200, 1, 4,   0, 0, 0,   200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 4,   0, 0, 0,   0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 4,   0, 0, 0,   1,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 4,   0, 0, 0,   2,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 4,   0, 0, 0,   3,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 2,   0, 0, 0,   0,  1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 2,   0, 0, 0,   0,  0, 1, 0));
        // en gating with prescale=1: psc holds while en is low.
        vecs.push_back(mk(0, 0, 1, 0,   1, 9,   0, 1, 0,   0,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 9,   0, 1, 0,   0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 9,   0, 1, 0,   0,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 9,   0, 1, 0,   1,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 9,   0, 1, 0,   1,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 9,   0, 1, 0,   2,  0, 1, 0));
        // Reset beats load.
        vecs.push_back(mk(1, 1, 1, 5,   1, 9,   0, 1, 0,   0,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // One-shot up to 255, then hold with en high for 10 cycles.
        apply(mk(0, 0, 1, 253, 1, 255, 1, 0, 0, 253, 0, 0, 0), "os_load");
        apply(mk(0, 1, 0, 0,   1, 255, 1, 0, 0, 254, 0, 0, 0), "os_254");
        apply(mk(0, 1, 0, 0,   1, 255, 1, 0, 0, 255, 0, 0, 0), "os_255");
        apply(mk(0, 1, 0, 0,   1, 255, 1, 0, 0, 255, 1, 0, 1), "os_term");
        for (int k = 0; k < 10; k++) begin
            // Dropping oneshot must not leave DONE.
            apply(mk(0, 1, 0, 0, 1, 255, 0, 0, 0, 255, 0, 1, 1),
                  $sformatf("os_hold%0d", k));
        end
        apply(mk(0, 0, 1, 0,   1, 255, 0, 0, 0, 0,   0, 1, 0), "os_reload");
        apply(mk(0, 1, 0, 0,   1, 255, 0, 0, 0, 1,   0, 1, 0), "os_resume");

        // Enter DONE again, then reset from DONE.
        apply(mk(0, 0, 1, 1,   1, 1,   1, 0, 0, 1,   0, 1, 0), "done_load");
        apply(mk(0, 1, 0, 0,   1, 1,   1, 0, 0, 1,   1, 1, 1), "done_term");
        apply(mk(1, 1, 0, 0,   1, 1,   1, 0, 0, 0,   0, 0, 0), "done_rst");

        // max_val=0, prescale=0, wrap: tc stays high on every step.
        apply(mk(0, 1, 0, 0,   1, 0,   0, 0, 0, 0,   1, 0, 0), "b2b_0");
        apply(mk(0, 1, 0, 0,   1, 0,   0, 0, 0, 0,   1, 1, 0), "b2b_1");
        apply(mk(0, 1, 0, 0,   1, 0,   0, 0, 0, 0,   1, 1, 0), "b2b_2");
        apply(mk(0, 0, 0, 0,   1, 0,   0, 0, 0, 0,   0, 1, 0), "b2b_stop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
